pixel_line_reader: RTL and testbench
====================================

Name: pixel_line_reader

Overview:
- Receiving end of the colour-write interface. The compute-side sequencer emits one 8-bit RRRGGGBB colour per grid node, addressed by column, then pulses a line-done strobe.
- This block captures those writes into a double-buffered line store. It then streams each completed line out, in column order, as 24-bit RGB pixels with x/y coordinates.
- The stream uses a valid/ready handshake towards the display/SRAM write-back path.
- It decouples grid compute timing from display timing.

Parameters:
WIDTH, 64, pixels (grid columns) per line
HEIGHT, 64, lines per frame; pix_y wraps after HEIGHT-1
ADDR_W, 8, width of wr_addr
X_W, 8, width of pix_x
Y_W, 8, width of pix_y

Ports:
clk_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe for one colour byte
wr_addr  in  ADDR_W  column index of the colour byte
wr_data  in  8  colour, RRRGGGBB
wr_done  in  1  one-cycle pulse: current write line complete
pix_valid  out  1  pixel outputs hold a valid pixel
pix_ready  in  1  downstream accepts the pixel when pix_valid && pix_ready
pix_r  out  8  expanded red
pix_g  out  8  expanded green
pix_b  out  8  expanded blue
pix_x  out  X_W  column of the current pixel
pix_y  out  Y_W  line of the current pixel
busy  out  1  readout in progress, or a swap is pending
line_done  out  1  one-cycle pulse after the last pixel of a line is accepted
overrun  out  1  sticky: a wr_done arrived while a swap was already pending

Behaviour:
- Reset values: pix_valid=0, pix_r/g/b=0, pix_x=0, pix_y=0, busy=0, line_done=0, overrun=0. Reset also sets wr_bank=0, rd_bank=1, pending=0, state IDLE.
- Line store contents are not reset.
- Reset mid-stream aborts readout immediately. Pixels not yet accepted are discarded.

Write side:
- Two banks of WIDTH x 8 bits.
- When wr_en=1 and wr_addr<WIDTH, wr_data is written to wr_bank[wr_addr] on the same edge.
- When wr_addr>=WIDTH, the write is ignored.
- Writes are accepted in every state.

Swap:
- Trigger: wr_done sampled and (state==IDLE or pending==1 at end of line).
- Action: swap wr_bank/rd_bank and begin readout.
- If wr_done arrives while streaming and pending=0: set pending=1.
- If wr_done arrives while pending=1: set overrun=1 and leave pending=1. One swap still occurs later; the later writes share that bank.
- wr_done and a final write in the same cycle: the write lands in the old wr_bank before the swap.

State machine:
- IDLE: on wr_done, swap and go to PRIME.
- PRIME: present read address 0 to the synchronous-read store; go to STREAM.
- STREAM:
  - Data is registered into the output holding register and pix_valid=1.
  - pix_valid first rises two clocks after the edge that samples wr_done.
  - Outputs hold stable while pix_valid && !pix_ready.
  - On accept, the next address is prefetched so that one pixel per clock sustains while pix_ready=1.
  - On acceptance of x=WIDTH-1: pix_valid drops next cycle and line_done pulses.
  - pix_y then increments, wrapping HEIGHT-1 -> 0.
  - If pending=1: clear pending, swap, go to PRIME. Otherwise go to IDLE.
- busy = (state!=IDLE) | pending.

Colour expansion (combinational from the stored byte, registered with it):
- r3=d[7:5], g3=d[4:2], b2=d[1:0].
- pix_r={r3,r3,r3[2:1]}
- pix_g={g3,g3,g3[2:1]}
- pix_b={b2,b2,b2,b2}
- pix_x is the column of the held pixel, 0..WIDTH-1. It never wraps mid-line.

Test Plan:
- Reset, then write addr k data k for k=0..63, pulse wr_done, hold pix_ready=1 -> first pix_valid 2 clocks later. Pixels x=0..63, y=0 on consecutive clocks. line_done pulses once. busy falls. pix_y=1 afterwards.
- Colour mapping: data 8'hE0 -> (255,0,0); 8'b110_011_01 -> (0xDB,0x6D,0x55); 8'hFF -> (255,255,255); 8'h00 -> (0,0,0).
- Backpressure: toggle pix_ready pseudo-randomly during a line -> pixel outputs stay stable while stalled. No pixel is dropped or duplicated. Exactly 64 accepts occur.
- Double buffering: during streaming of line A, write line B and pulse wr_done once -> busy stays 1 and line B streams immediately after line A with y+1. A second wr_done before B starts sets overrun=1.
- Out-of-range write and wrap: write addr 64 with 8'hE0 -> no store change. Stream 64 lines -> pix_y wraps 63 -> 0.
- Assert reset mid-line at x=20 -> next cycle all outputs are at reset values. A subsequent wr_done restarts at x=0, y=0.

Source files
------------

// File: rtl/pixel_line_reader.sv
// pixel_line_reader
// Captures per-column colour bytes into a double-buffered line store and
// streams each completed line out as 24-bit RGB pixels with x/y coordinates.
//
// Ports:
//   clk_50, reset        clock (rising edge) and synchronous active-high reset
//   wr_en/addr/data      colour byte write (RRRGGGBB) into the write bank
//   wr_done              one-cycle pulse: write line complete, request swap
//   pix_valid/pix_ready  valid/ready handshake of the pixel stream
//   pix_r/g/b            expanded 8-bit colour channels
//   pix_x/pix_y          column/line of the held pixel
//   busy                 readout in progress or a swap is pending
//   line_done            pulse after the last pixel of a line is accepted
//   overrun              sticky: wr_done arrived while a swap was pending
module pixel_line_reader #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int ADDR_W = 8,
  parameter int X_W    = 8,
  parameter int Y_W    = 8
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              wr_done,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              busy,
  output logic              line_done,
  output logic              overrun
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_e;

  state_e         state_q, state_d;
  logic           wr_bank_q, wr_bank_d;   // read bank is always the other one
  logic           pending_q, pending_d;
  logic           overrun_q, overrun_d;
  logic           line_done_q, line_done_d;
  logic           pix_valid_q, pix_valid_d;
  logic           s1_valid_q, s1_valid_d; // rd_byte_q holds the next pixel
  logic [X_W-1:0] rd_addr_q, rd_addr_d;   // next column to fetch
  logic [X_W-1:0] pix_x_q, pix_x_d;
  logic [Y_W-1:0] pix_y_q, pix_y_d;
  logic [7:0]     pix_r_q, pix_r_d;
  logic [7:0]     pix_g_q, pix_g_d;
  logic [7:0]     pix_b_q, pix_b_d;

  logic [7:0]     mem [2][WIDTH];
  logic [7:0]     rd_byte_q;
  logic           rd_en;
  logic [AW-1:0]  rd_idx;
  logic           accept, last_accept, load, swap;
  logic [2:0]     r3, g3;
  logic [1:0]     b2;

  assign r3 = rd_byte_q[7:5];
  assign g3 = rd_byte_q[4:2];
  assign b2 = rd_byte_q[1:0];

  // Two-stage read: rd_byte_q runs one column ahead of the holding register,
  // so an accept can be followed by a new pixel on the very next clock.
  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    line_done_d = 1'b0;
    pix_valid_d = pix_valid_q;
    s1_valid_d  = s1_valid_q;
    rd_addr_d   = rd_addr_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_r_d     = pix_r_q;
    pix_g_d     = pix_g_q;
    pix_b_d     = pix_b_q;
    rd_en       = 1'b0;
    rd_idx      = rd_addr_q[AW-1:0];
    swap        = 1'b0;
    accept      = pix_valid_q && pix_ready;
    last_accept = accept && (pix_x_q == X_W'(WIDTH - 1));
    load        = (state_q == STREAM) && s1_valid_q && (!pix_valid_q || accept);

    case (state_q)
      IDLE: begin
        if (wr_done) begin
          swap    = 1'b1;
          state_d = PRIME;
        end
      end
      PRIME: begin
        rd_en      = 1'b1;
        rd_idx     = '0;
        rd_addr_d  = X_W'(1);
        s1_valid_d = 1'b1;
        state_d    = STREAM;
        if (wr_done) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
      end
      STREAM: begin
        if (load) begin
          pix_valid_d = 1'b1;
          pix_r_d     = {r3, r3, r3[2:1]};
          pix_g_d     = {g3, g3, g3[2:1]};
          pix_b_d     = {b2, b2, b2, b2};
          pix_x_d     = rd_addr_q - X_W'(1);
          if (rd_addr_q == X_W'(WIDTH)) begin
            s1_valid_d = 1'b0;
          end else begin
            rd_en     = 1'b1;
            rd_addr_d = rd_addr_q + X_W'(1);
          end
        end
        if (last_accept) begin
          pix_valid_d = 1'b0;
          line_done_d = 1'b1;
          pix_y_d     = (pix_y_q == Y_W'(HEIGHT - 1)) ? '0 : pix_y_q + Y_W'(1);
          // A wr_done landing on the end-of-line cycle becomes the new request.
          if (pending_q) begin
            swap      = 1'b1;
            pending_d = wr_done;
            state_d   = PRIME;
          end else if (wr_done) begin
            swap    = 1'b1;
            state_d = PRIME;
          end else begin
            state_d = IDLE;
          end
        end else if (wr_done) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (swap) wr_bank_d = ~wr_bank_q;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      line_done_q <= 1'b0;
      pix_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_r_q     <= '0;
      pix_g_q     <= '0;
      pix_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      line_done_q <= line_done_d;
      pix_valid_q <= pix_valid_d;
      s1_valid_q  <= s1_valid_d;
      rd_addr_q   <= rd_addr_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_r_q     <= pix_r_d;
      pix_g_q     <= pix_g_d;
      pix_b_q     <= pix_b_d;
    end
  end

  // Line store: not reset. A write in the swap cycle uses the old write bank.
  always_ff @(posedge clk_50) begin
    if (wr_en && (wr_addr < ADDR_W'(WIDTH))) begin
      mem[wr_bank_q][wr_addr[AW-1:0]] <= wr_data;
    end
    if (rd_en) begin
      rd_byte_q <= mem[~wr_bank_q][rd_idx];
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_r     = pix_r_q;
  assign pix_g     = pix_g_q;
  assign pix_b     = pix_b_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign busy      = (state_q != IDLE) | pending_q;
  assign line_done = line_done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pixel_line_reader.sv
module tb_pixel_line_reader;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_done;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_r, pix_g, pix_b, pix_x, pix_y;
  logic       busy, line_done, overrun;

  pixel_line_reader #(.WIDTH(64), .HEIGHT(64), .ADDR_W(8), .X_W(8), .Y_W(8)) dut (
    .clk_50(clk_50), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_done(wr_done), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .line_done(line_done),
    .overrun(overrun)
  );

  always #5 clk_50 = ~clk_50;

  typedef struct packed {
    logic [7:0] r, g, b, x, y;
  } pix_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  pix_t sb[$];
  logic [7:0] mm [2][64];
  int   mwb = 0;
  int   exp_y = 0;
  int   rmode = 0;
  int   acc_count = 0;
  int   ld_count = 0;
  logic busy_at_ld = 1'b0;
  logic stall_prev = 1'b0;
  logic last_acc = 1'b0;
  logic [40:0] held;

  task automatic chk(input string tag, input logic ok);
    n_checks++;
    if (ok === 1'b1) n_pass++;
    else $error("FAIL %s", tag);
  endtask

  function automatic pix_t mk(input logic [7:0] d, input int x, input int y);
    pix_t p;
    p.r = {d[7:5], d[7:5], d[7:6]};
    p.g = {d[4:2], d[4:2], d[4:3]};
    p.b = {d[1:0], d[1:0], d[1:0], d[1:0]};
    p.x = 8'(x);
    p.y = 8'(y);
    return p;
  endfunction

  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk_50);
      #1;
      case (rmode)
        0: pix_ready = 1'b0;
        1: pix_ready = 1'b1;
        2: pix_ready = ($urandom_range(0, 1) == 1);
        default: pix_ready = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  always @(negedge clk_50) begin
    if (!reset) begin
      if (last_acc) begin
        chk("line_done_pulse", line_done === 1'b1);
        chk("valid_drop", pix_valid === 1'b0);
        ld_count++;
        busy_at_ld = busy;
      end else begin
        chk("no_stray_line_done", line_done === 1'b0);
      end
      if (stall_prev) begin
        chk("stall_hold", {pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y} === held);
      end
      if (pix_valid && pix_ready) begin
        chk("sb_nonempty", (sb.size() > 0) === 1'b1);
        if (sb.size() > 0) begin
          chk("pixel", {pix_r, pix_g, pix_b, pix_x, pix_y} === sb.pop_front());
        end
        acc_count++;
      end
      stall_prev = pix_valid && !pix_ready;
      held       = {pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y};
      last_acc   = pix_valid && pix_ready && (pix_x == 8'd63);
    end else begin
      stall_prev = 1'b0;
      last_acc   = 1'b0;
    end
  end

  task automatic wr(input int a, input logic [7:0] d);
    @(posedge clk_50);
    #1;
    wr_en   = 1'b1;
    wr_addr = 8'(a);
    wr_data = d;
    if (a < 64) mm[mwb][a] = d;
  endtask

  task automatic fill(input int seed);
    for (int k = 0; k < 64; k++) wr(k, 8'(k * 7 + seed));
  endtask

  task automatic raw_done();
    @(posedge clk_50);
    #1;
    wr_en   = 1'b0;
    wr_done = 1'b1;
    @(posedge clk_50);
    #1;
    wr_done = 1'b0;
  endtask

  task automatic do_done();
    for (int x = 0; x < 64; x++) sb.push_back(mk(mm[mwb][x], x, exp_y));
    exp_y = (exp_y + 1) % 64;
    mwb   = 1 - mwb;
    raw_done();
  endtask

  task automatic wait_lines(input int n);
    int target;
    int cnt;
    target = ld_count + n;
    cnt = 0;
    while (ld_count < target && cnt < 3000) begin
      @(posedge clk_50);
      cnt++;
    end
    chk("line_wait", (ld_count >= target) === 1'b1);
  endtask

  task automatic wait_valid();
    int cnt;
    cnt = 0;
    @(negedge clk_50);
    while (!pix_valid && cnt < 200) begin
      @(negedge clk_50);
      cnt++;
    end
    chk("wait_valid", pix_valid === 1'b1);
  endtask

  task automatic step_accept();
    @(posedge clk_50);
    #2 rmode = 1;
    @(posedge clk_50);
    #2 rmode = 0;
    @(posedge clk_50);
    @(negedge clk_50);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc0;
    logic [7:0] ya;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_done = 1'b0;
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    chk("rst_valid", pix_valid === 1'b0);
    chk("rst_rgb", {pix_r, pix_g, pix_b} === 24'h0);
    chk("rst_xy", {pix_x, pix_y} === 16'h0);
    chk("rst_flags", {busy, line_done, overrun} === 3'b000);
    @(posedge clk_50);
    #1 reset = 1'b0;

    rmode = 1;
    for (int k = 0; k < 64; k++) wr(k, 8'(k));
    do_done();
    @(negedge clk_50);
    chk("lat_e0_valid", pix_valid === 1'b0);
    chk("lat_e0_busy", busy === 1'b1);
    @(negedge clk_50);
    chk("lat_e1_valid", pix_valid === 1'b0);
    @(negedge clk_50);
    chk("lat_e2_valid", pix_valid === 1'b1);
    chk("first_x", pix_x === 8'd0);
    n = 0;
    while (!line_done && n < 200) begin
      @(negedge clk_50);
      n++;
    end
    chk("line_cycles", n === 64);
    chk("busy_after_line", busy === 1'b0);
    chk("y_after_line", pix_y === 8'd1);

    rmode = 0;
    fill(3);
    wr(0, 8'hE0); wr(1, 8'b110_011_01); wr(2, 8'hFF); wr(3, 8'h00);
    do_done();
    wait_valid();
    chk("col_E0", {pix_r, pix_g, pix_b} === 24'hFF0000);
    step_accept();
    chk("col_CD", {pix_r, pix_g, pix_b} === 24'hDB6D55);
    step_accept();
    chk("col_FF", {pix_r, pix_g, pix_b} === 24'hFFFFFF);
    step_accept();
    chk("col_00", {pix_r, pix_g, pix_b} === 24'h000000);
    chk("col_x3", pix_x === 8'd3);
    rmode = 1;
    wait_lines(1);

    for (int k = 0; k < 64; k++) wr(k, 8'($urandom_range(0, 255)));
    acc0 = acc_count;
    rmode = 2;
    do_done();
    wait_lines(1);
    chk("bp_accepts", (acc_count - acc0) === 64);
    chk("bp_sb_empty", sb.size() === 0);

    rmode = 3;
    fill(11);
    ya = 8'(exp_y);
    do_done();
    fill(29);
    chk("dbl_a_streaming", {busy, pix_y} === {1'b1, ya});
    do_done();
    @(negedge clk_50);
    chk("dbl_pending_busy", busy === 1'b1);
    chk("dbl_no_overrun", overrun === 1'b0);
    raw_done();
    @(negedge clk_50);
    chk("dbl_overrun", overrun === 1'b1);
    chk("dbl_still_a", pix_y === ya);
    rmode = 1;
    wait_lines(1);
    chk("dbl_busy_between", busy_at_ld === 1'b1);
    wait_lines(1);
    chk("dbl_busy_end", busy_at_ld === 1'b0);
    chk("dbl_sb_empty", sb.size() === 0);

    fill(5);
    wr(64, 8'hE0);
    wr(255, 8'hE0);
    do_done();
    wait_lines(1);

    for (int i = 0; i < 64; i++) begin
      do_done();
      wait_lines(1);
      @(negedge clk_50);
      chk("wrap_y", pix_y === 8'(exp_y));
    end

    do_done();
    n = 0;
    @(negedge clk_50);
    while (!(pix_valid && pix_x == 8'd20) && n < 200) begin
      @(negedge clk_50);
      n++;
    end
    chk("reach_x20", pix_x === 8'd20);
    reset = 1'b1;
    @(negedge clk_50);
    chk("mid_rst_valid", pix_valid === 1'b0);
    chk("mid_rst_rgbxy", {pix_r, pix_g, pix_b, pix_x, pix_y} === 40'h0);
    chk("mid_rst_flags", {busy, line_done, overrun} === 3'b000);
    sb.delete();
    mwb = 0;
    exp_y = 0;
    @(posedge clk_50);
    #1 reset = 1'b0;
    do_done();
    wait_valid();
    chk("restart_xy", {pix_x, pix_y} === 16'h0);
    wait_lines(1);
    chk("final_sb_empty", sb.size() === 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
